// File: rtl/sysmem_icb_arb.sv
// rtl/sysmem_icb_arb.sv - two-requester round-robin ICB arbiter for the shared system-memory port
//
// Ports:
//   clk, rst               single clock, synchronous active-high reset
//   m0_icb_cmd_* / rsp_*   E203 core master (cmd: valid/ready/read/addr/wdata/wmask,
//                          rsp: valid/ready/err/rdata)
//   m1_icb_cmd_* / rsp_*   accelerator memory master, same shape as m0
//   s_icb_cmd_* / rsp_*    toward the external memory slave
//   outs_cnt               number of outstanding commands (0..OUTS_N)
//   busy                   outs_cnt != 0
module sysmem_icb_arb #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int OUTS_N = 2
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            m0_icb_cmd_valid,
    output logic            m0_icb_cmd_ready,
    input  logic            m0_icb_cmd_read,
    input  logic [AW-1:0]   m0_icb_cmd_addr,
    input  logic [DW-1:0]   m0_icb_cmd_wdata,
    input  logic [DW/8-1:0] m0_icb_cmd_wmask,
    output logic            m0_icb_rsp_valid,
    input  logic            m0_icb_rsp_ready,
    output logic            m0_icb_rsp_err,
    output logic [DW-1:0]   m0_icb_rsp_rdata,

    input  logic            m1_icb_cmd_valid,
    output logic            m1_icb_cmd_ready,
    input  logic            m1_icb_cmd_read,
    input  logic [AW-1:0]   m1_icb_cmd_addr,
    input  logic [DW-1:0]   m1_icb_cmd_wdata,
    input  logic [DW/8-1:0] m1_icb_cmd_wmask,
    output logic            m1_icb_rsp_valid,
    input  logic            m1_icb_rsp_ready,
    output logic            m1_icb_rsp_err,
    output logic [DW-1:0]   m1_icb_rsp_rdata,

    output logic            s_icb_cmd_valid,
    input  logic            s_icb_cmd_ready,
    output logic            s_icb_cmd_read,
    output logic [AW-1:0]   s_icb_cmd_addr,
    output logic [DW-1:0]   s_icb_cmd_wdata,
    output logic [DW/8-1:0] s_icb_cmd_wmask,
    input  logic            s_icb_rsp_valid,
    output logic            s_icb_rsp_ready,
    input  logic            s_icb_rsp_err,
    input  logic [DW-1:0]   s_icb_rsp_rdata,

    output logic [3:0]      outs_cnt,
    output logic            busy
);

    // ID FIFO storage is sized for the largest legal OUTS_N; only the
    // first OUTS_N entries are ever addressed.
    logic [7:0] fifo_q;
    logic [2:0] wptr;
    logic [2:0] rptr;
    logic [3:0] cnt;
    logic       rr_last;
    logic       lock;
    logic       lock_id;

    logic       fifo_full;
    logic       fifo_empty;
    logic       head;
    logic       gnt;
    logic       gnt_valid;
    logic       push;
    logic       pop;
    logic [2:0] wptr_nxt;
    logic [2:0] rptr_nxt;

    assign fifo_full  = (cnt == 4'(OUTS_N));
    assign fifo_empty = (cnt == 4'd0);
    assign head       = fifo_q[rptr];
    assign wptr_nxt   = (wptr == 3'(OUTS_N - 1)) ? 3'd0 : wptr + 3'd1;
    assign rptr_nxt   = (rptr == 3'(OUTS_N - 1)) ? 3'd0 : rptr + 3'd1;

    // Grant is forced to m0 during reset so the payload mux shows m0.
    always_comb begin
        gnt = 1'b0;
        if (rst) begin
            gnt = 1'b0;
        end else if (lock) begin
            gnt = lock_id;
        end else if (m0_icb_cmd_valid && !m1_icb_cmd_valid) begin
            gnt = 1'b0;
        end else if (m1_icb_cmd_valid && !m0_icb_cmd_valid) begin
            gnt = 1'b1;
        end else if (m0_icb_cmd_valid && m1_icb_cmd_valid) begin
            gnt = ~rr_last;
        end
    end

    assign gnt_valid = gnt ? m1_icb_cmd_valid : m0_icb_cmd_valid;

    // Command path: full FIFO blocks issue outright, even if a pop happens
    // in the same cycle, to keep the ready path free of response logic.
    assign s_icb_cmd_valid  = ~rst & gnt_valid & ~fifo_full;
    assign s_icb_cmd_read   = gnt ? m1_icb_cmd_read  : m0_icb_cmd_read;
    assign s_icb_cmd_addr   = gnt ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
    assign s_icb_cmd_wdata  = gnt ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
    assign s_icb_cmd_wmask  = gnt ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;
    assign m0_icb_cmd_ready = ~rst & ~gnt & s_icb_cmd_ready & ~fifo_full;
    assign m1_icb_cmd_ready = ~rst &  gnt & s_icb_cmd_ready & ~fifo_full;

    // Response path: an empty FIFO stalls any stray slave response.
    assign m0_icb_rsp_valid = ~rst & s_icb_rsp_valid & ~fifo_empty & ~head;
    assign m1_icb_rsp_valid = ~rst & s_icb_rsp_valid & ~fifo_empty &  head;
    assign m0_icb_rsp_err   = s_icb_rsp_err;
    assign m1_icb_rsp_err   = s_icb_rsp_err;
    assign m0_icb_rsp_rdata = s_icb_rsp_rdata;
    assign m1_icb_rsp_rdata = s_icb_rsp_rdata;
    assign s_icb_rsp_ready  = ~rst & ~fifo_empty &
                              (head ? m1_icb_rsp_ready : m0_icb_rsp_ready);

    assign push = s_icb_cmd_valid & s_icb_cmd_ready;
    assign pop  = s_icb_rsp_valid & s_icb_rsp_ready;

    assign outs_cnt = cnt;
    assign busy     = (cnt != 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_q  <= 8'd0;
            wptr    <= 3'd0;
            rptr    <= 3'd0;
            cnt     <= 4'd0;
            rr_last <= 1'b1;
            lock    <= 1'b0;
            lock_id <= 1'b0;
        end else begin
            if (push) begin
                fifo_q[wptr] <= gnt;
                wptr         <= wptr_nxt;
                rr_last      <= gnt;
                lock         <= 1'b0;
            end else if (s_icb_cmd_valid) begin
                // Slave stalled: hold this grant until the handshake.
                lock    <= 1'b1;
                lock_id <= gnt;
            end
            if (pop) begin
                rptr <= rptr_nxt;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 4'd1;
                2'b01:   cnt <= cnt - 4'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_sysmem_icb_arb.sv
// tb/tb_sysmem_icb_arb.sv - self-checking bench for sysmem_icb_arb
module tb_sysmem_icb_arb;
    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int OUTS_N = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            m0_icb_cmd_valid, m0_icb_cmd_ready, m0_icb_cmd_read;
    logic [AW-1:0]   m0_icb_cmd_addr;
    logic [DW-1:0]   m0_icb_cmd_wdata;
    logic [DW/8-1:0] m0_icb_cmd_wmask;
    logic            m0_icb_rsp_valid, m0_icb_rsp_ready, m0_icb_rsp_err;
    logic [DW-1:0]   m0_icb_rsp_rdata;
    logic            m1_icb_cmd_valid, m1_icb_cmd_ready, m1_icb_cmd_read;
    logic [AW-1:0]   m1_icb_cmd_addr;
    logic [DW-1:0]   m1_icb_cmd_wdata;
    logic [DW/8-1:0] m1_icb_cmd_wmask;
    logic            m1_icb_rsp_valid, m1_icb_rsp_ready, m1_icb_rsp_err;
    logic [DW-1:0]   m1_icb_rsp_rdata;
    logic            s_icb_cmd_valid, s_icb_cmd_ready, s_icb_cmd_read;
    logic [AW-1:0]   s_icb_cmd_addr;
    logic [DW-1:0]   s_icb_cmd_wdata;
    logic [DW/8-1:0] s_icb_cmd_wmask;
    logic            s_icb_rsp_valid, s_icb_rsp_ready, s_icb_rsp_err;
    logic [DW-1:0]   s_icb_rsp_rdata;
    logic [3:0]      outs_cnt;
    logic            busy;

    sysmem_icb_arb #(.AW(AW), .DW(DW), .OUTS_N(OUTS_N)) dut (
        .clk(clk), .rst(rst),
        .m0_icb_cmd_valid(m0_icb_cmd_valid), .m0_icb_cmd_ready(m0_icb_cmd_ready),
        .m0_icb_cmd_read(m0_icb_cmd_read), .m0_icb_cmd_addr(m0_icb_cmd_addr),
        .m0_icb_cmd_wdata(m0_icb_cmd_wdata), .m0_icb_cmd_wmask(m0_icb_cmd_wmask),
        .m0_icb_rsp_valid(m0_icb_rsp_valid), .m0_icb_rsp_ready(m0_icb_rsp_ready),
        .m0_icb_rsp_err(m0_icb_rsp_err), .m0_icb_rsp_rdata(m0_icb_rsp_rdata),
        .m1_icb_cmd_valid(m1_icb_cmd_valid), .m1_icb_cmd_ready(m1_icb_cmd_ready),
        .m1_icb_cmd_read(m1_icb_cmd_read), .m1_icb_cmd_addr(m1_icb_cmd_addr),
        .m1_icb_cmd_wdata(m1_icb_cmd_wdata), .m1_icb_cmd_wmask(m1_icb_cmd_wmask),
        .m1_icb_rsp_valid(m1_icb_rsp_valid), .m1_icb_rsp_ready(m1_icb_rsp_ready),
        .m1_icb_rsp_err(m1_icb_rsp_err), .m1_icb_rsp_rdata(m1_icb_rsp_rdata),
        .s_icb_cmd_valid(s_icb_cmd_valid), .s_icb_cmd_ready(s_icb_cmd_ready),
        .s_icb_cmd_read(s_icb_cmd_read), .s_icb_cmd_addr(s_icb_cmd_addr),
        .s_icb_cmd_wdata(s_icb_cmd_wdata), .s_icb_cmd_wmask(s_icb_cmd_wmask),
        .s_icb_rsp_valid(s_icb_rsp_valid), .s_icb_rsp_ready(s_icb_rsp_ready),
        .s_icb_rsp_err(s_icb_rsp_err), .s_icb_rsp_rdata(s_icb_rsp_rdata),
        .outs_cnt(outs_cnt), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: queue of issuing requester per outstanding command,
    // the requester whose command is stalled at the slave (if any), and
    // the requester that won last.
    bit q[$];
    bit held;
    bit held_id;
    bit last_win = 1'b1;
    bit acc0, acc1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit winner();
        if (held) return held_id;
        if (m0_icb_cmd_valid && !m1_icb_cmd_valid) return 1'b0;
        if (m1_icb_cmd_valid && !m0_icb_cmd_valid) return 1'b1;
        if (m0_icb_cmd_valid && m1_icb_cmd_valid) return ~last_win;
        return 1'b0;
    endfunction

    // One clock: inputs already driven after a falling edge.
    task automatic cycle();
        bit g, full, gv, scv, hv, hd, r0v, r1v, srr, push, pop;
        acc0 = 1'b0;
        acc1 = 1'b0;
        #1;
        if (rst) begin
            chk("rst_s_cmd_valid", s_icb_cmd_valid, 0);
            chk("rst_s_rsp_ready", s_icb_rsp_ready, 0);
            chk("rst_m0_cmd_ready", m0_icb_cmd_ready, 0);
            chk("rst_m1_cmd_ready", m1_icb_cmd_ready, 0);
            chk("rst_m0_rsp_valid", m0_icb_rsp_valid, 0);
            chk("rst_m1_rsp_valid", m1_icb_rsp_valid, 0);
            chk("rst_addr_m0", s_icb_cmd_addr, m0_icb_cmd_addr);
            @(posedge clk);
            q.delete();
            held = 1'b0;
            last_win = 1'b1;
        end else begin
            g    = winner();
            full = (q.size() == OUTS_N);
            gv   = g ? m1_icb_cmd_valid : m0_icb_cmd_valid;
            scv  = gv && !full;
            chk("s_cmd_valid", s_icb_cmd_valid, scv);
            chk("m0_cmd_ready", m0_icb_cmd_ready, !g && s_icb_cmd_ready && !full);
            chk("m1_cmd_ready", m1_icb_cmd_ready, g && s_icb_cmd_ready && !full);
            chk("s_cmd_addr", s_icb_cmd_addr, g ? m1_icb_cmd_addr : m0_icb_cmd_addr);
            chk("s_cmd_read", s_icb_cmd_read, g ? m1_icb_cmd_read : m0_icb_cmd_read);
            chk("s_cmd_wdata", s_icb_cmd_wdata, g ? m1_icb_cmd_wdata : m0_icb_cmd_wdata);
            hv  = (q.size() > 0);
            hd  = hv ? q[0] : 1'b0;
            r0v = s_icb_rsp_valid && hv && !hd;
            r1v = s_icb_rsp_valid && hv && hd;
            srr = hv && (hd ? m1_icb_rsp_ready : m0_icb_rsp_ready);
            chk("m0_rsp_valid", m0_icb_rsp_valid, r0v);
            chk("m1_rsp_valid", m1_icb_rsp_valid, r1v);
            chk("s_rsp_ready", s_icb_rsp_ready, srr);
            if (r0v) chk("m0_rsp_rdata", {m0_icb_rsp_err, m0_icb_rsp_rdata}, {s_icb_rsp_err, s_icb_rsp_rdata});
            if (r1v) chk("m1_rsp_rdata", {m1_icb_rsp_err, m1_icb_rsp_rdata}, {s_icb_rsp_err, s_icb_rsp_rdata});
            push = scv && s_icb_cmd_ready;
            pop  = s_icb_rsp_valid && srr;
            @(posedge clk);
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(g);
                last_win = g;
                held = 1'b0;
                if (g) acc1 = 1'b1; else acc0 = 1'b1;
            end else if (scv) begin
                held = 1'b1;
                held_id = g;
            end
        end
        #1;
        chk("outs_cnt", outs_cnt, q.size());
        chk("busy", busy, q.size() != 0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        m0_icb_cmd_valid = 0; m0_icb_cmd_read = 0; m0_icb_cmd_addr = 0;
        m0_icb_cmd_wdata = 32'h0000_00A0; m0_icb_cmd_wmask = 4'hF; m0_icb_rsp_ready = 0;
        m1_icb_cmd_valid = 0; m1_icb_cmd_read = 0; m1_icb_cmd_addr = 0;
        m1_icb_cmd_wdata = 32'h0000_00B1; m1_icb_cmd_wmask = 4'h3; m1_icb_rsp_ready = 0;
        s_icb_cmd_ready = 0; s_icb_rsp_valid = 0; s_icb_rsp_err = 0; s_icb_rsp_rdata = 0;
        @(negedge clk);
        cycle();
        do_reset();

        // Single requester read with a response two cycles later
        m0_icb_cmd_valid = 1; m0_icb_cmd_read = 1; m0_icb_cmd_addr = 32'h8000_0000;
        s_icb_cmd_ready = 1;
        cycle();
        chk("t1_outs_one", outs_cnt, 1);
        m0_icb_cmd_valid = 0;
        cycle();
        s_icb_rsp_valid = 1; s_icb_rsp_rdata = 32'hDEAD_BEEF; m0_icb_rsp_ready = 1;
        #1;
        chk("t1_m0_rsp_valid", m0_icb_rsp_valid, 1);
        chk("t1_m0_rdata", m0_icb_rsp_rdata, 32'hDEAD_BEEF);
        chk("t1_m1_rsp_valid", m1_icb_rsp_valid, 0);
        cycle();
        s_icb_rsp_valid = 0;
        chk("t1_outs_zero", outs_cnt, 0);

        // Contention: strict alternation starting with m0 after reset
        do_reset();
        m0_icb_cmd_valid = 1; m1_icb_cmd_valid = 1;
        m0_icb_rsp_ready = 1; m1_icb_rsp_ready = 1;
        for (int i = 0; i < 8; i++) begin
            m0_icb_cmd_addr = 32'h1000 + i;
            m1_icb_cmd_addr = 32'h2000 + i;
            s_icb_rsp_valid = (q.size() > 0);
            s_icb_rsp_rdata = 32'hC000 + i;
            #1;
            chk("cont_gnt_m1", m1_icb_cmd_ready, (i % 2));
            cycle();
        end
        m0_icb_cmd_valid = 0; m1_icb_cmd_valid = 0;
        for (int i = 0; i < 4 && q.size() > 0; i++) begin
            s_icb_rsp_valid = 1;
            cycle();
        end
        s_icb_rsp_valid = 0;
        chk("cont_drained", outs_cnt, 0);

        // Lock: m1 stalled three cycles, m0 must wait
        do_reset();
        m1_icb_cmd_valid = 1; m1_icb_cmd_addr = 32'h3000; s_icb_cmd_ready = 0;
        for (int i = 0; i < 3; i++) begin
            m0_icb_cmd_valid = (i > 0); m0_icb_cmd_addr = 32'h4000;
            #1;
            chk("lock_m0_ready", m0_icb_cmd_ready, 0);
            chk("lock_addr_m1", s_icb_cmd_addr, 32'h3000);
            cycle();
        end
        s_icb_cmd_ready = 1;
        #1;
        chk("lock_m1_handshake", m1_icb_cmd_ready, 1);
        cycle();
        m1_icb_cmd_addr = 32'h3004;
        #1;
        chk("lock_m0_next", m0_icb_cmd_ready, 1);
        chk("lock_addr_m0", s_icb_cmd_addr, 32'h4000);
        cycle();
        m0_icb_cmd_valid = 0; m1_icb_cmd_valid = 0;

        // Full FIFO: third command waits, no bypass on a same-cycle pop
        do_reset();
        m0_icb_cmd_valid = 1; s_icb_cmd_ready = 1; s_icb_rsp_valid = 0;
        for (int i = 0; i < 2; i++) begin
            m0_icb_cmd_addr = 32'h5000 + i;
            cycle();
        end
        m0_icb_cmd_addr = 32'h5002;
        #1;
        chk("full_no_issue", s_icb_cmd_valid, 0);
        chk("full_outs", outs_cnt, 2);
        cycle();
        s_icb_rsp_valid = 1; m0_icb_rsp_ready = 1;
        #1;
        chk("full_no_bypass", s_icb_cmd_valid, 0);
        chk("full_pop_ready", s_icb_rsp_ready, 1);
        cycle();
        s_icb_rsp_valid = 0;
        #1;
        chk("full_issue_next", s_icb_cmd_valid, 1);
        cycle();
        m0_icb_cmd_valid = 0;

        // Stray response, then reset with two outstanding
        do_reset();
        s_icb_rsp_valid = 1;
        #1;
        chk("stray_s_rsp_ready", s_icb_rsp_ready, 0);
        chk("stray_m0_rsp_valid", m0_icb_rsp_valid, 0);
        chk("stray_m1_rsp_valid", m1_icb_rsp_valid, 0);
        cycle();
        s_icb_rsp_valid = 0;
        m0_icb_cmd_valid = 1;
        cycle();
        cycle();
        chk("pre_rst_outs", outs_cnt, 2);
        m0_icb_cmd_valid = 0;
        do_reset();
        chk("post_rst_outs", outs_cnt, 0);
        m0_icb_cmd_valid = 1; m1_icb_cmd_valid = 1;
        #1;
        chk("post_rst_gnt_m0", m0_icb_cmd_ready, 1);
        chk("post_rst_m1_wait", m1_icb_cmd_ready, 0);
        cycle();
        m0_icb_cmd_valid = 0; m1_icb_cmd_valid = 0;

        // Randomized traffic; requesters hold a command until accepted
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if (!m0_icb_cmd_valid || acc0) begin
                m0_icb_cmd_valid = $urandom_range(0, 1);
                m0_icb_cmd_addr  = $urandom;
                m0_icb_cmd_read  = $urandom_range(0, 1);
                m0_icb_cmd_wdata = $urandom;
            end
            if (!m1_icb_cmd_valid || acc1) begin
                m1_icb_cmd_valid = $urandom_range(0, 1);
                m1_icb_cmd_addr  = $urandom;
                m1_icb_cmd_read  = $urandom_range(0, 1);
                m1_icb_cmd_wdata = $urandom;
            end
            s_icb_cmd_ready  = ($urandom_range(0, 3) != 0);
            s_icb_rsp_valid  = $urandom_range(0, 1);
            s_icb_rsp_err    = $urandom_range(0, 1);
            s_icb_rsp_rdata  = $urandom;
            m0_icb_rsp_ready = ($urandom_range(0, 3) != 0);
            m1_icb_rsp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sysmem_icb_arb.md
# sysmem_icb_arb

Two-requester ICB arbiter that shares the SoC system-memory ICB port between the E203 core (`sysmem_icb_*` master) and the image-recognition accelerator's memory master. It sits between `e203_subsys_top`'s sysmem interface and the external memory slave. Command arbitration is round-robin with grant locking. Responses are returned in order, steered by a FIFO of grant IDs that also bounds the number of outstanding transactions.

## Interface
Parameters:
- `AW`, 32, command address width.
- `DW`, 32, data width; `wmask` width is `DW/8`.
- `OUTS_N`, 2, maximum outstanding commands (1..8); this is the ID FIFO depth.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `m0_icb_cmd_valid/ready/read/addr/wdata/wmask`  in/out/in/in/in/in  1/1/1/AW/DW/DW/8  core command channel.
- `m0_icb_rsp_valid/ready/err/rdata`  out/in/out/out  1/1/1/DW  core response channel.
- `m1_icb_cmd_*`, `m1_icb_rsp_*`  same as m0  accelerator channels.
- `s_icb_cmd_valid/ready/read/addr/wdata/wmask`  out/in/out/out/out/out  command to the memory slave.
- `s_icb_rsp_valid/ready/err/rdata`  in/out/in/in  response from the memory slave.
- `outs_cnt`  out  4  current outstanding count, 0..OUTS_N.
- `busy`  out  1  `outs_cnt != 0`.

## Operation
- **State registers:**
  - `rr_last`: last granted requester; reset value 1, so m0 has priority first.
  - `lock`, `lock_id`: hold the grant while a command waits for `ready`.
  - ID FIFO: `OUTS_N` entries, 1 bit each, with read/write pointers and a count.
- **Arbitration (combinational, from registered state):**
  - If `lock` is set, `gnt = lock_id`.
  - Otherwise, if only one requester is valid, grant that requester.
  - Otherwise, if both are valid, grant `~rr_last`.
- **Command path:**
  - Payload and valid are muxed from the granted requester.
  - `s_icb_cmd_valid = gnt_valid & ~fifo_full`.
  - The granted requester's `cmd_ready` is `s_icb_cmd_ready & ~fifo_full`; the other requester's `cmd_ready` is 0.
- **Command handshake** (`s_icb_cmd_valid & s_icb_cmd_ready`):
  - Push `gnt` into the FIFO.
  - Set `rr_last <= gnt`.
  - Clear `lock`.
- **Lock:** if `s_icb_cmd_valid & ~s_icb_cmd_ready`, set `lock <= 1` and `lock_id <= gnt`. The grant cannot change until that handshake completes.
- **Response path:**
  - The FIFO head selects the destination.
  - `mX_icb_rsp_valid = s_icb_rsp_valid & ~fifo_empty & (head == X)`.
  - `err` and `rdata` go to both requesters (they are qualified by valid).
  - `s_icb_rsp_ready` = the head requester's `rsp_ready & ~fifo_empty`.
  - A response handshake pops the FIFO.
- **FIFO full:** no command is issued, and no bypass is allowed even when a pop happens in the same cycle. The command issues the following cycle.
- **FIFO empty:** `s_icb_rsp_ready = 0` and both `mX_rsp_valid = 0`. A stray slave response is stalled, never misrouted.
- **Simultaneous push and pop** (FIFO neither full nor empty): both take effect and `outs_cnt` is unchanged.
- **Reset:**
  - While `rst` is high, every valid/ready output is forced to 0.
  - `rst` clears the FIFO, `lock` and `outs_cnt`, and sets `rr_last = 1`.
  - Reset asserted mid-transaction drops all in-flight IDs. The slave is reset with the same `rst`.

## Timing
- Command and response paths are purely combinational: zero-cycle latency through the arbiter.
- Grant, `lock`, `rr_last` and FIFO contents update one cycle after the qualifying handshake.
- `outs_cnt` reflects pushes and pops from the next cycle onward.
- Reset values of the outputs:
  - `outs_cnt = 0`, `busy = 0`.
  - All `*_valid` and `*_ready` outputs are 0.
  - Payload outputs follow the m0 mux input.
- Back-to-back commands at one per cycle are sustained until `OUTS_N` commands are outstanding.
- Fairness: when both requesters continuously request, grants alternate strictly, m0 first after reset.

## Test plan
- **Single requester:** m0 issues a read to 0x8000_0000, slave ready=1, slave rsp 2 cycles later with rdata=0xDEADBEEF → m0 rsp_valid with that data, m1 sees no valid, `outs_cnt` goes 1 then 0.
- **Contention:** m0 and m1 both valid for 4 commands each, slave always ready, immediate responses → grant order m0,m1,m0,m1,…; responses are delivered to the requester that issued each command, in the same order.
- **Lock:** m1 granted while slave `cmd_ready` is held low for 3 cycles, and m0 asserts valid during that time → grant stays m1 and m0 `cmd_ready` stays 0; m0 is granted in the cycle after m1's handshake.
- **Full FIFO:** `OUTS_N=2`, issue 3 commands with the slave withholding responses → the third `s_cmd_valid` stays 0 and `outs_cnt=2`. Then release one response → the third command issues the next cycle.
- **Stray response and reset:** `s_rsp_valid=1` with the FIFO empty → `s_rsp_ready=0` and no `mX_rsp_valid`. Assert `rst` with 2 commands outstanding → next cycle `outs_cnt=0`, all handshake outputs are 0, and the first grant after reset goes to m0 under contention.
